// File: rtl/field_commit_scheduler.sv
// Shadow-buffered field/score handoff from game logic to the renderer; commits only on vsync falling edges.
// Optional UPD_DROP_CNT_EN adds oDROP_CNT, a saturating count of overwritten uncommitted updates.
module field_commit_scheduler #(
  parameter int unsigned FIELD_BITS = 100,
  parameter int unsigned SCORE_BITS = 32,
  parameter int unsigned FRAME_DIV  = 1
) (
  input  logic                  iVGA_CLK,
  input  logic                  iRST,
  input  logic                  iVS,
  input  logic                  iUPD_REQ,
  input  logic [0:FIELD_BITS-1] iUPD_FIELD,
  input  logic [SCORE_BITS-1:0] iUPD_SCORE,
  output logic                  oUPD_ACK,
  output logic [0:FIELD_BITS-1] oFIELD,
  output logic [SCORE_BITS-1:0] oSCORE,
  output logic                  oPENDING,
  output logic [15:0]           oFRAME_CNT
`ifdef UPD_DROP_CNT_EN
  ,
  output logic [7:0]            oDROP_CNT
`endif
);

  localparam int unsigned DIV_W    = 8;
  localparam int unsigned FRAME_W  = 16;
  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(FRAME_DIV - 1);

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_PEND,
    ST_COMMIT
  } state_t;

  state_t                r_state;
  state_t                w_next;
  logic                  r_vs_d;
  logic [DIV_W-1:0]      r_div_cnt;
  logic [FRAME_W-1:0]    r_frame_cnt;
  logic                  r_ack;
  logic                  r_pending;
  logic [0:FIELD_BITS-1] r_shadow_field;
  logic [SCORE_BITS-1:0] r_shadow_score;
  logic [0:FIELD_BITS-1] r_field;
  logic [SCORE_BITS-1:0] r_score;

  logic w_vs_fall;
  logic w_div_wrap;
  logic w_req_new;
  logic w_accept;
  logic w_commit;

  // A request still high during its own ACK cycle is the old request, not a new one.
  assign w_vs_fall  = r_vs_d & ~iVS;
  assign w_div_wrap = w_vs_fall && (r_div_cnt == DIV_LAST);
  assign w_req_new  = iUPD_REQ & ~r_ack;

  always_ff @(posedge iVGA_CLK) begin
    if (iRST) r_state <= ST_IDLE;
    else      r_state <= w_next;
  end

  always_comb begin
    w_next   = r_state;
    w_accept = 1'b0;
    w_commit = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (w_req_new) begin
          w_accept = 1'b1;
          w_next   = ST_PEND;
        end
      end
      ST_PEND: begin
        // A commit opportunity wins over a same-cycle request, which stays held off.
        if (w_div_wrap) begin
          w_next = ST_COMMIT;
        end else if (w_req_new) begin
          w_accept = 1'b1;
        end
      end
      ST_COMMIT: begin
        w_commit = 1'b1;
        w_next   = ST_IDLE;
      end
      default: w_next = ST_IDLE;
    endcase
  end

  // Vsync edge detect, frame counter and commit divider.
  always_ff @(posedge iVGA_CLK) begin
    if (iRST) begin
      r_vs_d      <= 1'b1;
      r_div_cnt   <= '0;
      r_frame_cnt <= '0;
    end else begin
      r_vs_d <= iVS;
      if (w_vs_fall) begin
        r_frame_cnt <= r_frame_cnt + FRAME_W'(1);
        r_div_cnt   <= w_div_wrap ? '0 : r_div_cnt + DIV_W'(1);
      end
    end
  end

  // Shadow capture, handshake and committed copies.
  always_ff @(posedge iVGA_CLK) begin
    if (iRST) begin
      r_ack          <= 1'b0;
      r_pending      <= 1'b0;
      r_shadow_field <= '0;
      r_shadow_score <= '0;
      r_field        <= '0;
      r_score        <= '0;
    end else begin
      r_ack     <= w_accept;
      r_pending <= (w_next != ST_IDLE);
      if (w_accept) begin
        r_shadow_field <= iUPD_FIELD;
        r_shadow_score <= iUPD_SCORE;
      end
      if (w_commit) begin
        r_field <= r_shadow_field;
        r_score <= r_shadow_score;
      end
    end
  end

`ifdef UPD_DROP_CNT_EN
  logic [7:0] r_drop_cnt;
  logic       w_overwrite;

  assign w_overwrite = w_accept && (r_state == ST_PEND);

  always_ff @(posedge iVGA_CLK) begin
    if (iRST)                                  r_drop_cnt <= '0;
    else if (w_overwrite && r_drop_cnt != 8'hFF) r_drop_cnt <= r_drop_cnt + 8'd1;
  end

  assign oDROP_CNT = r_drop_cnt;
`endif

  assign oUPD_ACK   = r_ack;
  assign oFIELD     = r_field;
  assign oSCORE     = r_score;
  assign oPENDING   = r_pending;
  assign oFRAME_CNT = r_frame_cnt;

endmodule

// File: tb/tb_field_commit_scheduler.sv
// Directed bench for field_commit_scheduler: one FRAME_DIV=1 and one FRAME_DIV=3 instance on shared stimulus.
module tb_field_commit_scheduler;

  localparam int unsigned FB = 100;
  localparam int unsigned SB = 32;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic          rst, vs, req;
  logic [0:FB-1] fld;
  logic [SB-1:0] scr;

  logic          ack1, pend1, ack3, pend3;
  logic [0:FB-1] field1, field3;
  logic [SB-1:0] score1, score3;
  logic [15:0]   frame1, frame3;
`ifdef UPD_DROP_CNT_EN
  logic [7:0]    drop1, drop3;
`endif

  int n_vec = 0;
  int n_err = 0;
  int ack_cnt = 0;

  logic [0:FB-1] ef_zero;
  logic [0:FB-1] ef_bit0;

  field_commit_scheduler #(.FIELD_BITS(FB), .SCORE_BITS(SB), .FRAME_DIV(1)) dut1 (
    .iVGA_CLK(clk), .iRST(rst), .iVS(vs), .iUPD_REQ(req),
    .iUPD_FIELD(fld), .iUPD_SCORE(scr),
    .oUPD_ACK(ack1), .oFIELD(field1), .oSCORE(score1),
    .oPENDING(pend1), .oFRAME_CNT(frame1)
`ifdef UPD_DROP_CNT_EN
    , .oDROP_CNT(drop1)
`endif
  );

  field_commit_scheduler #(.FIELD_BITS(FB), .SCORE_BITS(SB), .FRAME_DIV(3)) dut3 (
    .iVGA_CLK(clk), .iRST(rst), .iVS(vs), .iUPD_REQ(req),
    .iUPD_FIELD(fld), .iUPD_SCORE(scr),
    .oUPD_ACK(ack3), .oFIELD(field3), .oSCORE(score3),
    .oPENDING(pend3), .oFRAME_CNT(frame3)
`ifdef UPD_DROP_CNT_EN
    , .oDROP_CNT(drop3)
`endif
  );

  always @(posedge clk) if (ack1) ack_cnt <= ack_cnt + 1;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic chk_f(input string tag, input logic [0:FB-1] obs, input logic [0:FB-1] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic vsync();
    vs = 1'b0;
    step();
    step();
    vs = 1'b1;
    step();
    step();
  endtask

  initial begin
    ef_zero = '0;
    ef_bit0 = '0;
    ef_bit0[0] = 1'b1;
    rst = 1'b1; vs = 1'b1; req = 1'b0; fld = '0; scr = '0;
    step();
    step();
    chk_f("rst_field", field1, ef_zero);
    chk("rst_score", score1, 32'd0);
    chk("rst_ack", 32'(ack1), 32'd0);
    chk("rst_pend", 32'(pend1), 32'd0);
    chk("rst_frame", 32'(frame1), 32'd0);
    rst = 1'b0;
    step();

    // Idle frames: counter advances, outputs hold, no ACK.
    vsync(); vsync(); vsync();
    chk("idle_frame", 32'(frame1), 32'd3);
    chk_f("idle_field", field1, ef_zero);
    chk("idle_score", score1, 32'd0);
    chk("idle_ack_cnt", 32'(ack_cnt), 32'd0);

    // Single update, committed two cycles after the next vsync fall.
    fld = ef_bit0; scr = 32'd5; req = 1'b1;
    step();
    chk("t2_ack", 32'(ack1), 32'd1);
    chk("t2_pend", 32'(pend1), 32'd1);
    req = 1'b0;
    step();
    chk("t2_ack_pulse", 32'(ack1), 32'd0);
    chk_f("t2_field_hold", field1, ef_zero);
    vs = 1'b0;
    step();
    chk_f("t2_field_lat1", field1, ef_zero);
    chk("t2_pend_lat1", 32'(pend1), 32'd1);
    chk("t2_frame", 32'(frame1), 32'd4);
    step();
    chk_f("t2_field", field1, ef_bit0);
    chk("t2_score", score1, 32'd5);
    chk("t2_pend_clr", 32'(pend1), 32'd0);
    vs = 1'b1;
    step(); step();

    // Two updates in one frame; REQ held through the ACK cycle is not re-accepted.
    scr = 32'd7; req = 1'b1;
    step();
    chk("t3_ack7", 32'(ack1), 32'd1);
    step();
    chk("t3_hold_noack", 32'(ack1), 32'd0);
    req = 1'b0;
    step();
    scr = 32'd9; req = 1'b1;
    step();
    chk("t3_ack9", 32'(ack1), 32'd1);
    req = 1'b0;
    step();
    vs = 1'b0;
    step(); step();
    chk("t3_score", score1, 32'd9);
    chk("t3_pend", 32'(pend1), 32'd0);
`ifdef UPD_DROP_CNT_EN
    chk("t3_drop", 32'(drop1), 32'd1);
`endif
    vs = 1'b1;
    step(); step();

    // REQ in PEND coincident with vsync fall: old shadow commits, new REQ waits for IDLE.
    scr = 32'd11; req = 1'b1;
    step();
    req = 1'b0;
    step();
    chk("t4_pend", 32'(pend1), 32'd1);
    scr = 32'd13; req = 1'b1; vs = 1'b0;
    step();
    chk("t4_commit_noack", 32'(ack1), 32'd0);
    chk("t4_commit_pend", 32'(pend1), 32'd1);
    chk("t4_commit_old", score1, 32'd9);
    step();
    chk("t4_score11", score1, 32'd11);
    chk("t4_idle_noack", 32'(ack1), 32'd0);
    chk("t4_idle_pend", 32'(pend1), 32'd0);
    step();
    chk("t4_ack13", 32'(ack1), 32'd1);
    chk("t4_pend13", 32'(pend1), 32'd1);
    req = 1'b0; vs = 1'b1;
    step(); step();
    chk("t4_score_hold", score1, 32'd11);
    vs = 1'b0;
    step(); step();
    chk("t4_score13", score1, 32'd13);
    chk("t4_frame", 32'(frame1), 32'd7);
`ifdef UPD_DROP_CNT_EN
    chk("t4_drop", 32'(drop1), 32'd1);
`endif
    vs = 1'b1;
    step(); step();

    // Reset while pending discards the shadow.
    fld = '1; scr = 32'd21; req = 1'b1;
    step();
    req = 1'b0;
    step();
    chk("t6_pend", 32'(pend1), 32'd1);
    rst = 1'b1;
    step();
    chk("t6_rst_pend", 32'(pend1), 32'd0);
    chk_f("t6_rst_field", field1, ef_zero);
    chk("t6_rst_score", score1, 32'd0);
    chk("t6_rst_frame", 32'(frame1), 32'd0);
    rst = 1'b0;
    vsync();
    chk("t6_score", score1, 32'd0);
    chk_f("t6_field", field1, ef_zero);
    chk("t6_pend_after", 32'(pend1), 32'd0);
    chk("t6_frame", 32'(frame1), 32'd1);
`ifdef UPD_DROP_CNT_EN
    chk("t6_drop", 32'(drop1), 32'd0);
`endif

    // FRAME_DIV=3 commits only on the third vsync fall after reset.
    rst = 1'b1;
    step();
    rst = 1'b0;
    fld = '0; scr = 32'd3; req = 1'b1;
    step();
    chk("t5_ack", 32'(ack3), 32'd1);
    chk("t5_pend", 32'(pend3), 32'd1);
    req = 1'b0;
    step();
    vsync();
    chk("t5_f1_pend", 32'(pend3), 32'd1);
    chk("t5_f1_score", score3, 32'd0);
    chk("t5_f1_frame", 32'(frame3), 32'd1);
    chk("t5_div1_score", score1, 32'd3);
    vsync();
    chk("t5_f2_pend", 32'(pend3), 32'd1);
    chk("t5_f2_score", score3, 32'd0);
    vs = 1'b0;
    step();
    chk("t5_f3_frame", 32'(frame3), 32'd3);
    chk("t5_f3_pend", 32'(pend3), 32'd1);
    chk("t5_f3_hold", score3, 32'd0);
    step();
    chk("t5_score", score3, 32'd3);
    chk("t5_pend_clr", 32'(pend3), 32'd0);
    vs = 1'b1;
    step(); step();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
